// File: rtl/lfsr_gen_pkg.sv
// Shared definitions for the LFSR generator: parameter limits, the
// update-kind encoding and a table of maximal-length feedback masks.
package lfsr_gen_pkg;

    localparam int unsigned LFSR_WIDTH_MIN = 3;
    localparam int unsigned LFSR_WIDTH_MAX = 32;
    localparam int unsigned LFSR_STEPS_MIN = 1;

    typedef enum logic [1:0] {
        UPD_HOLD = 2'd0,
        UPD_LOAD = 2'd1,
        UPD_ADV  = 2'd2
    } upd_e;

    // Bit i of the mask means state bit i feeds the XOR (tap n -> bit n-1).
    function automatic logic [31:0] lfsr_default_taps(input int unsigned w);
        logic [31:0] t;
        case (w)
            3:       t = 32'h0000_0006;
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0829;
            13:      t = 32'h0000_100D;
            14:      t = 32'h0000_2015;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_D008;
            17:      t = 32'h0001_2000;
            18:      t = 32'h0002_0400;
            19:      t = 32'h0004_0023;
            20:      t = 32'h0009_0000;
            21:      t = 32'h0014_0000;
            22:      t = 32'h0030_0000;
            23:      t = 32'h0042_0000;
            24:      t = 32'h00E1_0000;
            25:      t = 32'h0120_0000;
            26:      t = 32'h0200_0023;
            27:      t = 32'h0400_0013;
            28:      t = 32'h0900_0000;
            29:      t = 32'h1400_0000;
            30:      t = 32'h2000_0029;
            31:      t = 32'h4800_0000;
            32:      t = 32'h8020_0003;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci shift: feedback is the parity of the tapped bits, shifted in at bit 0.
module lfsr_step
    import lfsr_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH))
)(
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_state
);

    logic w_fb;

    assign w_fb    = ^(i_state & TAPS);
    assign o_state = {i_state[WIDTH-2:0], w_fb};

endmodule

// File: rtl/lfsr_gen.sv
// Loadable Fibonacci LFSR with multi-step advance, lock-up guard,
// wrap/period tracking against the last written reference, and target match.
module lfsr_gen
    import lfsr_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int unsigned      STEPS = 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             cen,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] steps,
    output logic [WIDTH-1:0] period,
    output logic             wrap,
    output logic             lockup,
    output logic             match
);

    generate
        if (WIDTH < LFSR_WIDTH_MIN || WIDTH > LFSR_WIDTH_MAX) begin : g_bad_width
            $error("lfsr_gen: WIDTH must be within 3..32");
        end
        if (STEPS < LFSR_STEPS_MIN || STEPS > WIDTH) begin : g_bad_steps
            $error("lfsr_gen: STEPS must be within 1..WIDTH");
        end
        if (TAPS == '0) begin : g_bad_taps
            $error("lfsr_gen: TAPS must be non-zero");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_gen: SEED must be non-zero");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_steps;
    logic [WIDTH-1:0] r_period;
    logic             r_wrap;
    logic             r_lockup;

    logic [WIDTH-1:0] w_chain [STEPS+1];
    logic [WIDTH-1:0] w_nxt;
    logic             w_nxt_zero;
    logic [WIDTH-1:0] w_adv_val;
    logic             w_seed_zero;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_steps_inc;
    logic             w_adv_wrap;
    upd_e             w_upd;

    assign w_chain[0] = r_count;

    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .i_state (w_chain[gi]),
            .o_state (w_chain[gi+1])
        );
    end

    assign w_nxt       = w_chain[STEPS];
    assign w_nxt_zero  = (w_nxt == '0);
    assign w_adv_val   = w_nxt_zero ? SEED : w_nxt;
    assign w_seed_zero = (seed_in == '0);
    assign w_load_val  = w_seed_zero ? SEED : seed_in;
    // Also serves as the new period on a wrap, since period = steps + 1.
    assign w_steps_inc = (&r_steps) ? r_steps : r_steps + 1'b1;
    assign w_adv_wrap  = (w_adv_val == r_ref);

    always_comb begin
        w_upd = UPD_HOLD;
        if (load) begin
            w_upd = UPD_LOAD;
        end else if (cen) begin
            w_upd = UPD_ADV;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= SEED;
            r_ref    <= SEED;
            r_steps  <= '0;
            r_period <= '0;
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
            case (w_upd)
                UPD_LOAD: begin
                    r_count  <= w_load_val;
                    r_ref    <= w_load_val;
                    r_steps  <= '0;
                    r_lockup <= w_seed_zero;
                end
                UPD_ADV: begin
                    r_count  <= w_adv_val;
                    r_lockup <= w_nxt_zero;
                    if (w_adv_wrap) begin
                        r_wrap   <= 1'b1;
                        r_period <= w_steps_inc;
                        r_steps  <= '0;
                    end else begin
                        r_steps  <= w_steps_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count  = r_count;
    assign steps  = r_steps;
    assign period = r_period;
    assign wrap   = r_wrap;
    assign lockup = r_lockup;
    assign match  = (r_count == target);

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: a driver pushes expected post-edge state, a
// negedge monitor pops and compares; directed checks use hand-computed values.
module tb_lfsr_gen;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [7:0] seed_in;
    logic       cen;
    logic [7:0] target;
    logic [7:0] count, steps, period;
    logic       wrap, lockup, match;

    logic       load2;
    logic [7:0] seed2;
    logic       cen2;
    logic [7:0] target2;
    logic [7:0] count2, steps2, period2;
    logic       wrap2, lockup2, match2;

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .load(load), .seed_in(seed_in), .cen(cen),
        .target(target), .count(count), .steps(steps), .period(period),
        .wrap(wrap), .lockup(lockup), .match(match)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .load(load2), .seed_in(seed2), .cen(cen2),
        .target(target2), .count(count2), .steps(steps2), .period(period2),
        .wrap(wrap2), .lockup(lockup2), .match(match2)
    );

    typedef struct {
        logic [7:0] count;
        logic [7:0] steps;
        logic [7:0] period;
        logic       wrap;
        logic       lockup;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] m_count, m_ref, m_steps, m_period;
    logic       m_wrap, m_lock;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] f_shift(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    task automatic model_reset();
        m_count = 8'h01; m_ref = 8'h01; m_steps = 8'h00; m_period = 8'h00;
        m_wrap = 1'b0;   m_lock = 1'b0;
    endtask

    task automatic model_apply(input logic ld, input logic [7:0] sd, input logic ce);
        logic [7:0] v;
        logic [7:0] inc;
        m_wrap = 1'b0;
        m_lock = 1'b0;
        if (ld) begin
            v = (sd == 8'h00) ? 8'h01 : sd;
            m_lock  = (sd == 8'h00);
            m_count = v;
            m_ref   = v;
            m_steps = 8'h00;
        end else if (ce) begin
            v = f_shift(m_count);
            if (v == 8'h00) begin
                v = 8'h01;
                m_lock = 1'b1;
            end
            m_count = v;
            inc = (m_steps == 8'hFF) ? 8'hFF : m_steps + 8'h01;
            if (v == m_ref) begin
                m_wrap   = 1'b1;
                m_period = inc;
                m_steps  = 8'h00;
            end else begin
                m_steps = inc;
            end
        end
    endtask

    // Drive one cycle of stimulus, then queue the state expected after that edge.
    task automatic step(input logic ld, input logic [7:0] sd, input logic ce);
        exp_t e;
        load = ld; seed_in = sd; cen = ce;
        @(posedge clk);
        #1;
        model_apply(ld, sd, ce);
        e.count = m_count; e.steps = m_steps; e.period = m_period;
        e.wrap = m_wrap;   e.lockup = m_lock;
        q.push_back(e);
    endtask

    task automatic drain();
        int tries = 0;
        while (q.size() != 0 && tries < 10) begin
            @(negedge clk);
            tries++;
        end
        #1;
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_count",  count,  e.count);
                chk("sb_steps",  steps,  e.steps);
                chk("sb_period", period, e.period);
                chk("sb_wrap",   wrap,   e.wrap);
                chk("sb_lockup", lockup, e.lockup);
                chk("sb_match",  match,  (e.count == target));
            end
        end
    end

    logic [7:0] hand_seq [6];
    int         wrap_cnt;
    int         wrap_at;

    initial begin
        hand_seq[0] = 8'h02; hand_seq[1] = 8'h04; hand_seq[2] = 8'h08;
        hand_seq[3] = 8'h11; hand_seq[4] = 8'h23; hand_seq[5] = 8'h47;
        rst_n = 1'b0; load = 1'b0; seed_in = 8'h00; cen = 1'b0; target = 8'h00;
        load2 = 1'b0; seed2 = 8'h00; cen2 = 1'b0; target2 = 8'h00;
        model_reset();
        #12;
        chk("rst_count",  count,  8'h01);
        chk("rst_steps",  steps,  8'h00);
        chk("rst_period", period, 8'h00);
        chk("rst_flags",  {wrap, lockup}, 2'b00);
        rst_n = 1'b1;

        // Sequence from reset with a target hit on 08.
        target = 8'h08;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 1'b1);
            #2;
            chk("seq_count", count, hand_seq[i]);
            chk("seq_steps", steps, i + 1);
            chk("seq_match", match, (hand_seq[i] == 8'h08));
        end

        // Asynchronous reset in the middle of a run.
        step(1'b0, 8'h00, 1'b0);
        drain();
        rst_n = 1'b0;
        #1;
        chk("async_count",  count,  8'h01);
        chk("async_steps",  steps,  8'h00);
        chk("async_period", period, 8'h00);
        chk("async_flags",  {wrap, lockup}, 2'b00);
        model_reset();
        #1;
        rst_n = 1'b1;

        // Full period: wrap only on advance 255.
        target = 8'h01;
        wrap_cnt = 0;
        wrap_at  = 0;
        for (int i = 1; i <= 255; i++) begin
            step(1'b0, 8'h00, 1'b1);
            #2;
            if (wrap) begin
                wrap_cnt++;
                wrap_at = i;
            end
        end
        chk("wrap_count",  wrap_cnt, 1);
        chk("wrap_at",     wrap_at, 255);
        chk("wrap_period", period, 8'd255);
        chk("wrap_state",  count, 8'h01);
        chk("wrap_steps",  steps, 8'h00);

        // Zero seed is replaced by SEED; load beats cen.
        step(1'b1, 8'h00, 1'b0);
        #2;
        chk("zload_count",  count,  8'h01);
        chk("zload_lockup", lockup, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        #2;
        chk("zload_lockup_clr", lockup, 1'b0);
        step(1'b1, 8'h5A, 1'b1);
        #2;
        chk("ldcen_count", count, 8'h5A);
        chk("ldcen_steps", steps, 8'h00);
        chk("ldcen_wrap",  wrap,  1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Two shifts per enabled cycle.
        target2 = 8'h11;
        cen2 = 1'b1;
        wrap_cnt = 0;
        wrap_at  = 0;
        for (int i = 1; i <= 255; i++) begin
            step(1'b0, 8'h00, 1'b0);
            #2;
            if (i == 1) chk("s2_count1", count2, 8'h04);
            if (i == 2) begin
                chk("s2_count2", count2, 8'h11);
                chk("s2_match",  match2, 1'b1);
            end
            if (wrap2) begin
                wrap_cnt++;
                wrap_at = i;
            end
        end
        cen2 = 1'b0;
        chk("s2_wrap_count", wrap_cnt, 1);
        chk("s2_wrap_at",    wrap_at, 255);
        chk("s2_period",     period2, 8'd255);
        chk("s2_state",      count2, 8'h01);
        chk("s2_lockup",     lockup2, 1'b0);

        // Random enable with occasional loads against the model.
        for (int i = 0; i < 2000; i++) begin
            logic       ld;
            logic [7:0] sd;
            ld = ($urandom_range(0, 63) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) target = 8'($urandom_range(0, 255));
            step(ld, sd, 1'($urandom_range(0, 1)));
        end
        step(1'b0, 8'h00, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
